// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: instruction field positions,
// fetch state encodings and the default reset PC.
package instruction_fetch_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int IMM_WIDTH  = 16;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// Combinational next-PC selection (jr / beq taken / sequential) and
// detection of a jr target that is not word-aligned.
module next_pc_calc
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic [IMM_WIDTH-1:0]  branch_imm,
  input  logic                  jump_enable,
  input  logic                  conditional_branch,
  input  logic                  alu_zero,
  input  logic [ADDR_WIDTH-1:0] jump_register_value,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] branch_offset_s;

  // Word offset: sign-extended immediate scaled by 4.
  assign branch_offset_s = {{(ADDR_WIDTH-IMM_WIDTH-2){branch_imm[IMM_WIDTH-1]}}, branch_imm, 2'b00};

  // jr has priority over beq; everything else falls through to pc+4.
  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    if (jump_enable && !conditional_branch) begin
      next_pc    = {jump_register_value[ADDR_WIDTH-1:2], 2'b00};
      misaligned = |jump_register_value[1:0];
    end else if (jump_enable && conditional_branch && alu_zero) begin
      next_pc    = pc_plus4 + branch_offset_s;
    end else begin
      next_pc    = pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, imem request/ready handshake, instruction
// register with valid/ready, and next-PC update at retire.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           instruction,
  output logic [5:0]            instruction_opcode,
  output logic [5:0]            instruction_func,
  output logic [ADDR_WIDTH-1:0] pc_current,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic                  pc_jump_enable,
  input  logic                  pc_conditional_branch,
  input  logic                  alu_zero,
  input  logic [ADDR_WIDTH-1:0] jump_register_value,
  output logic [31:0]           retired_count,
  output logic                  misaligned_jump
);

  fetch_state_t          state_r, state_next_s;
  logic                  load_s, retire_s;
  logic                  imem_req_r, inst_valid_r;
  logic [ADDR_WIDTH-1:0] pc_r, next_pc_s;
  logic [31:0]           instruction_r, retired_count_r;
  logic                  misaligned_r, jr_misaligned_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode plus capture/retire strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      IDLE: begin
        state_next_s = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          state_next_s = HOLD;
          load_s       = 1'b1;
        end else begin
          state_next_s = FETCH;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          state_next_s = FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Handshake outputs registered from the next state so they track state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_r   <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      imem_req_r   <= (state_next_s == FETCH);
      inst_valid_r <= (state_next_s == HOLD);
    end
  end

  next_pc_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc_calc (
    .pc_plus4            (pc_plus4),
    .branch_imm          (instruction_r[IMM_MSB:IMM_LSB]),
    .jump_enable         (pc_jump_enable),
    .conditional_branch  (pc_conditional_branch),
    .alu_zero            (alu_zero),
    .jump_register_value (jump_register_value),
    .next_pc             (next_pc_s),
    .misaligned          (jr_misaligned_s)
  );

  // Instruction register, PC, retire counter and sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r            <= RESET_PC;
      instruction_r   <= 32'h0000_0000;
      retired_count_r <= 32'h0000_0000;
      misaligned_r    <= 1'b0;
    end else begin
      if (load_s) begin
        instruction_r <= imem_rdata;
      end
      if (retire_s) begin
        pc_r            <= next_pc_s;
        retired_count_r <= retired_count_r + 32'd1;
        misaligned_r    <= misaligned_r | jr_misaligned_s;
      end
    end
  end

  assign imem_req           = imem_req_r;
  assign imem_addr          = pc_r;
  assign inst_valid         = inst_valid_r;
  assign instruction        = instruction_r;
  assign instruction_opcode = instruction_r[OPCODE_MSB:OPCODE_LSB];
  assign instruction_func   = instruction_r[FUNC_MSB:FUNC_LSB];
  assign pc_current         = pc_r;
  assign pc_plus4           = pc_r + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
  assign retired_count      = retired_count_r;
  assign misaligned_jump    = misaligned_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: transaction-level reference model,
// per-cycle output comparison and hand-computed literal checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, inst_valid, misaligned_jump;
  logic [31:0] imem_addr, imem_rdata, instruction, pc_current, pc_plus4, retired_count;
  logic [5:0]  instruction_opcode, instruction_func;
  logic        imem_ready = 1'b1, inst_ready = 1'b1;
  logic        je = 1'b0, cb = 1'b0, zf = 1'b0;
  logic [31:0] jrv = 32'h0;

  logic        d1_req, d1_valid, d1_mis;
  logic [31:0] d1_addr, d1_instr, d1_pc, d1_plus4, d1_count;
  logic [5:0]  d1_op, d1_fn;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: beq -1 at 0x10, otherwise addi r1,r0,<addr low half>.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h1000_FFFF;
    return {6'h08, 5'd0, 5'd1, a[15:0]};
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .instruction(instruction),
    .instruction_opcode(instruction_opcode), .instruction_func(instruction_func),
    .pc_current(pc_current), .pc_plus4(pc_plus4), .pc_jump_enable(je),
    .pc_conditional_branch(cb), .alu_zero(zf), .jump_register_value(jrv),
    .retired_count(retired_count), .misaligned_jump(misaligned_jump));

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(d1_req), .imem_addr(d1_addr),
    .imem_ready(1'b1), .imem_rdata(32'h2001_0000), .inst_valid(d1_valid),
    .inst_ready(1'b1), .instruction(d1_instr), .instruction_opcode(d1_op),
    .instruction_func(d1_fn), .pc_current(d1_pc), .pc_plus4(d1_plus4),
    .pc_jump_enable(1'b0), .pc_conditional_branch(1'b0), .alu_zero(1'b0),
    .jump_register_value(32'h0), .retired_count(d1_count), .misaligned_jump(d1_mis));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = waiting to start, 1 = memory request open, 2 = holding an instruction.
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_count = 32'h0;
  logic        m_flag = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_pc <= 32'h0; m_instr <= 32'h0; m_count <= 32'h0; m_flag <= 1'b0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1 && imem_ready) begin
      m_instr <= imem_rdata;
      m_phase <= 2;
    end else if (m_phase == 2 && inst_ready) begin
      m_phase <= 1;
      m_count <= m_count + 32'd1;
      if (je && !cb) begin
        m_pc <= jrv & 32'hFFFF_FFFC;
        if (jrv % 4 != 0) m_flag <= 1'b1;
      end else if (je && cb && zf) begin
        m_pc <= m_pc + 32'd4 + 32'($signed(m_instr[15:0]) * 4);
      end else begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_phase == 2});
    if (m_phase == 1) chk("imem_addr", imem_addr, m_pc);
    chk("pc_current", pc_current, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instruction", instruction, m_instr);
    chk("opcode", {26'd0, instruction_opcode}, {26'd0, m_instr[31:26]});
    chk("func", {26'd0, instruction_func}, {26'd0, m_instr[5:0]});
    chk("retired_count", retired_count, m_count);
    chk("misaligned_jump", {31'd0, misaligned_jump}, {31'd0, m_flag});
  end

  // Wrap-around instance: one request per two cycles walking up from 0xFFFF_FFFC.
  logic [31:0] d1_exp = 32'hFFFF_FFFC;
  logic [31:0] d1_seen [2];
  int          d1_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      d1_exp <= 32'hFFFF_FFFC;
      d1_n   <= 0;
    end else if (d1_req) begin
      chk("wrap_addr", d1_addr, d1_exp);
      chk("wrap_plus4", d1_plus4, d1_exp + 32'd4);
      if (d1_n < 2) d1_seen[d1_n] <= d1_addr;
      d1_n   <= d1_n + 1;
      d1_exp <= d1_exp + 32'd4;
    end
  end

  // Wait for a request, check its address, then move on to the first HOLD cycle.
  task automatic expect_fetch(input logic [31:0] addr, input string name, output int at);
    int n;
    n = 0;
    @(negedge clk);
    je = 1'b0; cb = 1'b0; zf = 1'b0; jrv = 32'h0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    at = cyc;
    if (!imem_req) chk({name, "_timeout"}, {31'd0, imem_req}, 32'd1);
    else chk(name, imem_addr, addr);
    n = 0;
    while (imem_req && n < 20) begin @(negedge clk); n++; end
  endtask

  initial begin
    int t0, t1, t2;
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tc;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc_current, 32'h0);
    chk("rst_count", retired_count, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    rst_n = 1'b1;

    // Sequential flow, zero-wait memory, consumer always ready.
    expect_fetch(32'h0, "seq_0", ta);
    expect_fetch(32'h4, "seq_4", ta);
    expect_fetch(32'h8, "seq_8", tb);
    chk("seq_spacing", tb - ta, 32'd2);
    expect_fetch(32'hC, "seq_c", tc);
    chk("seq_spacing2", tc - tb, 32'd2);
    chk("seq_count", retired_count, 32'd3);

    // beq -1 at 0x10: taken loops to itself, not taken falls through.
    expect_fetch(32'h10, "beq_at", ta);
    chk("beq_word", instruction, 32'h1000_FFFF);
    je = 1'b1; cb = 1'b1; zf = 1'b1;
    expect_fetch(32'h10, "beq_taken", ta);
    je = 1'b1; cb = 1'b1; zf = 1'b0;
    expect_fetch(32'h14, "beq_not_taken", ta);

    // jr: misaligned target sets the flag; aligned target leaves it set.
    je = 1'b1; cb = 1'b0; jrv = 32'h0000_0102;
    expect_fetch(32'h100, "jr_mis", ta);
    chk("jr_mis_flag", {31'd0, misaligned_jump}, 32'd1);
    je = 1'b1; cb = 1'b0; jrv = 32'h0000_0200;
    expect_fetch(32'h200, "jr_ok", ta);
    chk("jr_ok_flag", {31'd0, misaligned_jump}, 32'd1);

    // Memory wait for 3 cycles, then consumer stall for 2 cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h204);
      chk("stall_valid", {31'd0, inst_valid}, 32'd0);
      if (i == 3) begin imem_ready = 1'b1; inst_ready = 1'b0; end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_instr", instruction, 32'h2001_0204);
      chk("hold_opcode", {26'd0, instruction_opcode}, 32'h08);
      chk("hold_func", {26'd0, instruction_func}, 32'h04);
      chk("hold_pc", pc_current, 32'h204);
      chk("hold_count", retired_count, 32'd9);
    end
    inst_ready = 1'b1;
    expect_fetch(32'h208, "after_hold", ta);

    // Reset in the middle of a waiting request.
    imem_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_pc", pc_current, 32'h0);
    chk("mid_rst_instr", instruction, 32'h0);
    chk("mid_rst_count", retired_count, 32'h0);
    chk("mid_rst_flag", {31'd0, misaligned_jump}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    expect_fetch(32'h0, "restart_0", ta);
    expect_fetch(32'h4, "restart_4", ta);
    chk("restart_count", retired_count, 32'd1);

    repeat (2) @(negedge clk);
    chk("wrap_first", d1_seen[0], 32'hFFFF_FFFC);
    chk("wrap_second", d1_seen[1], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of `control_unit`. Holds the program counter and reads instruction words from instruction memory through a request/ready handshake. It latches each word into an instruction register and presents it with a valid/ready handshake. When the instruction retires, it applies the jump and branch decisions that `control_unit` produced for that instruction to select the next PC.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC and memory address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset. Must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  ADDR_WIDTH  read address; equals `pc_current` whenever `imem_req`=1.
- `imem_ready`  in  1  `imem_rdata` valid this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `inst_valid`  out  1  instruction register holds an instruction not yet retired.
- `inst_ready`  in  1  consumer retires the instruction this cycle.
- `instruction`  out  32  instruction register.
- `instruction_opcode`  out  6  `instruction[31:26]`, feeds `control_unit`.
- `instruction_func`  out  6  `instruction[5:0]`, feeds `control_unit`.
- `pc_current`  out  ADDR_WIDTH  address of the instruction in flight.
- `pc_plus4`  out  ADDR_WIDTH  `pc_current`+4, modulo 2^ADDR_WIDTH.
- `pc_jump_enable`  in  1  from `control_unit`; sampled at retire.
- `pc_conditional_branch`  in  1  from `control_unit`; sampled at retire.
- `alu_zero`  in  1  beq comparison result (rs==rt); sampled at retire.
- `jump_register_value`  in  ADDR_WIDTH  rs value for jr; sampled at retire.
- `retired_count`  out  32  number of retired instructions; wraps.
- `misaligned_jump`  out  1  sticky flag: a jr target had nonzero bits [1:0].

## Operation
- States: `IDLE` (reset state), `FETCH`, `HOLD`.
- `IDLE`: moves unconditionally to `FETCH` on the next clock.
- `FETCH`:
  - `imem_req`=1.
  - If `imem_ready`=1: `instruction`←`imem_rdata`, go to `HOLD`. Otherwise stay, holding the address stable.
- `HOLD`:
  - `inst_valid`=1, `imem_req`=0.
  - On `inst_ready`=1 (retire): update `pc_current` to the next PC, increment `retired_count`, go to `FETCH`.
- Next-PC priority, evaluated at retire:
  - `pc_jump_enable`=1 and `pc_conditional_branch`=0 (jr): `jump_register_value` with bits [1:0] forced to 0. Set `misaligned_jump` if the original bits [1:0] were ≠0.
  - `pc_jump_enable`=1, `pc_conditional_branch`=1 and `alu_zero`=1 (beq taken): `pc_plus4` + (sign-extended `instruction[15:0]` << 2).
  - Otherwise (including beq not taken): `pc_plus4`.
- Arithmetic: all PC arithmetic is ADDR_WIDTH bits, unsigned, wrapping. `pc_current`=2^32−4 with sequential flow goes to 0.
- Reset values:
  - State `IDLE`, `pc_current`=`RESET_PC`, `instruction`=0.
  - `inst_valid`=0, `imem_req`=0.
  - `retired_count`=0, `misaligned_jump`=0.
- Boundary conditions:
  - `imem_ready` outside `FETCH` is ignored.
  - `inst_ready` outside `HOLD` is ignored, with no count change.
  - Reset asserted mid-`FETCH` abandons the request. Instruction memory must tolerate a dropped request.
  - `retired_count` wraps from 0xFFFF_FFFF to 0.

## Timing
- First `imem_req` occurs in the first cycle after `rst_n` deasserts and is sampled high at a clock edge.
- Zero-wait memory: `imem_ready` in a `FETCH` cycle means `inst_valid`=1 in the next cycle.
- Retire in the first `HOLD` cycle means the next `FETCH` starts in the following cycle. Peak throughput is 1 instruction per 2 cycles.
- Each memory wait cycle adds 1 cycle. Each cycle `inst_ready` stays low in `HOLD` adds 1 cycle.
- `instruction`, `pc_current` and `pc_plus4` stay stable for the whole `HOLD` period.
- Control inputs are combinational from `instruction`. They must be valid in the retire cycle only.

## Structure
- Shared defs file, alongside the existing instruction/ALU defines:
  - opcode/func/imm field bit positions;
  - fetch state encodings;
  - default `RESET_PC`.
- Sub-module `next_pc_calc`: purely combinational next-PC selection and misalignment detection. It is instantiated once inside `instruction_fetch`.

## Test plan
- Reset then zero-wait memory returning `addi` words, with `inst_ready` tied high:
  - `imem_addr` sequence 0x0, 0x4, 0x8, …, one request every 2 cycles;
  - `retired_count` increments per retire.
- beq (opcode 0x04, imm=0xFFFF) at 0x10, `pc_jump_enable`=1, `pc_conditional_branch`=1, `alu_zero`=1 → next fetch 0x10. With `alu_zero`=0 → next fetch 0x14.
- jr with `jump_register_value`=0x0000_0102 → next fetch 0x100 and `misaligned_jump`=1. With 0x200 → next fetch 0x200 and the flag is unchanged.
- `imem_ready` held low 3 cycles → `imem_req`/`imem_addr` stable for 4 cycles and `inst_valid` stays 0. Then `inst_ready` held low 2 cycles → `instruction` stable and no PC change.
- `RESET_PC`=0xFFFF_FFFC with sequential flow → second fetch at 0x0.
- `rst_n` asserted mid-`FETCH` → all outputs return to reset values immediately. After release, fetch restarts at `RESET_PC`.
